// File: rtl/dual_ram_be_if.sv
// dual_ram_be_if: write/read bus of the byte-enabled simple-dual-port RAM.
// master drives requests, slave returns registered read data and valid.
interface dual_ram_be_if #(
   parameter int DW = 32,
   parameter int AW = 12
);
   localparam int BW = DW / 8;

   logic          w_en;
   logic [BW-1:0] w_be_i;
   logic [AW-1:0] w_addr_i;
   logic [DW-1:0] w_data_i;
   logic          r_en;
   logic [AW-1:0] r_addr_i;
   logic [DW-1:0] r_data_o;
   logic          r_valid_o;

   modport master (
      output w_en,
      output w_be_i,
      output w_addr_i,
      output w_data_i,
      output r_en,
      output r_addr_i,
      input  r_data_o,
      input  r_valid_o
   );

   modport slave (
      input  w_en,
      input  w_be_i,
      input  w_addr_i,
      input  w_data_i,
      input  r_en,
      input  r_addr_i,
      output r_data_o,
      output r_valid_o
   );
endinterface

// File: rtl/dual_ram_be.sv
// dual_ram_be: simple-dual-port RAM, byte write enables, 1/2-cycle read.
// Define DUAL_RAM_BE_FWD_EN for write-first collisions (default read-first).
module dual_ram_be #(
   parameter int DW      = 32,
   parameter int AW      = 12,
   parameter int MEM_NUM = 4096,
   parameter int RD_LAT  = 1
) (
   input  logic         clk,
   input  logic         rst,
   dual_ram_be_if.slave bus
);
   localparam int BW = DW / 8;
   localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
   localparam logic [AW:0] LIM = (AW + 1)'(MEM_NUM);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("dual_ram_be: RD_LAT must be 1 or 2, got %0d", RD_LAT);
   end
   if (DW % 8 != 0) begin : g_bad_dw
      $error("dual_ram_be: DW must be a multiple of 8, got %0d", DW);
   end
   if (MEM_NUM > (1 << AW)) begin : g_bad_num
      $error("dual_ram_be: MEM_NUM %0d exceeds 2**AW", MEM_NUM);
   end

   logic [DW-1:0] r_mem [MEM_NUM];

   logic          w_wr_ok;
   logic          w_rd_ok;
   logic          w_we;
   logic [IW-1:0] w_widx;
   logic [IW-1:0] w_ridx;
   logic [DW-1:0] w_rd_raw;
   logic [DW-1:0] w_rd_data;

   assign w_wr_ok = {1'b0, bus.w_addr_i} < LIM;
   assign w_rd_ok = {1'b0, bus.r_addr_i} < LIM;
   assign w_widx  = bus.w_addr_i[IW-1:0];
   assign w_ridx  = bus.r_addr_i[IW-1:0];

   // writes are suppressed while reset is held
   always_comb begin
      w_we = rst & bus.w_en & w_wr_ok;
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int k = 0; k < BW; k++) begin
            if (bus.w_be_i[k]) begin
               r_mem[w_widx][8*k +: 8] <= bus.w_data_i[8*k +: 8];
            end
         end
      end
   end

   assign w_rd_raw = w_rd_ok ? r_mem[w_ridx] : '0;

`ifdef DUAL_RAM_BE_FWD_EN
   logic w_hit;

   assign w_hit = bus.w_en & w_wr_ok & (bus.w_addr_i == bus.r_addr_i);

   // write-first: enabled lanes of a colliding write bypass the array
   always_comb begin
      w_rd_data = w_rd_raw;
      if (w_hit) begin
         for (int k = 0; k < BW; k++) begin
            if (bus.w_be_i[k]) begin
               w_rd_data[8*k +: 8] = bus.w_data_i[8*k +: 8];
            end
         end
      end
   end
`else
   assign w_rd_data = w_rd_raw;
`endif

   logic [DW-1:0] r_data;
   logic          r_valid;

   if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] r_s1_data;
      logic          r_s1_vld;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_s1_data <= '0;
            r_s1_vld  <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
         end else begin
            r_s1_vld <= bus.r_en;
            if (bus.r_en) begin
               r_s1_data <= w_rd_data;
            end
            r_valid <= r_s1_vld;
            if (r_s1_vld) begin
               r_data <= r_s1_data;
            end
         end
      end
   end else begin : g_lat1
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= bus.r_en;
            if (bus.r_en) begin
               r_data <= w_rd_data;
            end
         end
      end
   end

   assign bus.r_data_o  = r_data;
   assign bus.r_valid_o = r_valid;
endmodule
